// File: rtl/muldiv_pkg.sv
// Shared definitions for the EXE-stage RV32M multiply/divide unit.
// Holds the funct3 encodings, the FSM state type and the special divide constants.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

  // Magnitude of a possibly signed operand; INT_MIN maps onto itself, which is
  // the correct unsigned magnitude 2^31.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// 32-iteration unsigned restoring divider datapath, sequenced by the parent FSM.
// Exposes the next quotient/remainder so the final step can be written directly.
module muldiv_divider
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clear,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quot_next,
  output logic [XLEN-1:0] o_rem_next,
  output logic [4:0]      o_count
);

  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_divisor;
  logic [4:0]      r_count;

  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;

  // The dividend shifts out of the quotient register MSB-first while quotient
  // bits shift in at the bottom.
  assign w_shift     = {r_rem, r_quot[XLEN-1]};
  assign w_diff      = w_shift - {1'b0, r_divisor};
  assign w_fits      = ~w_diff[XLEN];
  assign o_rem_next  = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign o_quot_next = {r_quot[XLEN-2:0], w_fits};
  assign o_count     = r_count;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_count   <= '0;
    end else if (i_clear) begin
      r_quot  <= '0;
      r_rem   <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_quot    <= i_dividend;
      r_rem     <= '0;
      r_divisor <= i_divisor;
      r_count   <= 5'd31;
    end else if (i_step) begin
      r_quot <= o_quot_next;
      r_rem  <= o_rem_next;
      if (r_count != 5'd0) r_count <= r_count - 5'd1;
    end
  end

endmodule

// File: rtl/exe_muldiv_unit.sv
// EXE-stage RV32M multiply/divide unit: 2-cycle multiply, 33-cycle divide,
// 1-cycle special divides, with a combinational stall toward the pipeline front.
module exe_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            md_start,
  input  logic [2:0]      md_funct3,
  input  logic [XLEN-1:0] md_rs1,
  input  logic [XLEN-1:0] md_rs2,
  input  logic            md_hold,
  input  logic            md_kill,
  output logic [XLEN-1:0] md_result,
  output logic            md_done,
  output logic            md_stall
);

  md_state_e       r_state;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_in_signed;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_div_load;
  logic            w_div_step;
  logic [XLEN-1:0] w_quot_next;
  logic [XLEN-1:0] w_rem_next;
  logic [4:0]      w_count;

  logic signed [XLEN:0]     w_mul_a;
  logic signed [XLEN:0]     w_mul_b;
  logic signed [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]          w_mul_res;

  logic            w_sgn;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN-1:0] w_div_res;

  // Issue-side decode works on the live inputs because it acts on the latch edge.
  assign w_accept      = (r_state == IDLE) && md_start && !md_kill;
  assign w_in_signed   = ~md_funct3[0];
  assign w_div_zero    = (md_rs2 == '0);
  assign w_div_ovf     = w_in_signed && (md_rs1 == INT_MIN) && (md_rs2 == '1);
  assign w_special     = w_div_zero || w_div_ovf;
  assign w_special_res = w_div_zero ? (md_funct3[1] ? md_rs1 : DIV_BY_ZERO_Q)
                                    : (md_funct3[1] ? '0     : INT_MIN);
  assign w_div_load    = w_accept && md_funct3[2] && !w_special;
  assign w_div_step    = (r_state == DIV) && !md_kill;

  muldiv_divider u_divider (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (md_kill),
    .i_load      (w_div_load),
    .i_step      (w_div_step),
    .i_dividend  (abs_val(md_rs1, w_in_signed)),
    .i_divisor   (abs_val(md_rs2, w_in_signed)),
    .o_quot_next (w_quot_next),
    .o_rem_next  (w_rem_next),
    .o_count     (w_count)
  );

  // 33x33 signed product; only the low 64 of its 66 bits are ever returned.
  assign w_mul_a   = {((r_funct3 == F3_MULH) || (r_funct3 == F3_MULHSU)) && r_rs1[XLEN-1], r_rs1};
  assign w_mul_b   = {(r_funct3 == F3_MULH) && r_rs2[XLEN-1], r_rs2};
  assign w_prod    = 64'(w_mul_a) * 64'(w_mul_b);
  assign w_mul_res = (r_funct3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  assign w_sgn     = ~r_funct3[0];
  assign w_q_fix   = (w_sgn && (r_rs1[XLEN-1] ^ r_rs2[XLEN-1])) ? -w_quot_next : w_quot_next;
  assign w_r_fix   = (w_sgn && r_rs1[XLEN-1]) ? -w_rem_next : w_rem_next;
  assign w_div_res = r_funct3[1] ? w_r_fix : w_q_fix;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_funct3 <= '0;
      r_result <= '0;
    end else if (md_kill) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (md_start) begin
            r_rs1    <= md_rs1;
            r_rs2    <= md_rs2;
            r_funct3 <= md_funct3;
            if (!md_funct3[2]) begin
              r_state <= MUL;
            end else if (w_special) begin
              r_result <= w_special_res;
              r_state  <= DONE;
            end else begin
              r_state <= DIV;
            end
          end
        end
        MUL: begin
          r_result <= w_mul_res;
          r_state  <= DONE;
        end
        DIV: begin
          if (w_count == 5'd0) begin
            r_result <= w_div_res;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (!md_hold) r_state <= IDLE;
        end
      endcase
    end
  end

  assign md_result = r_result;
  assign md_done   = (r_state == DONE);
  assign md_stall  = !md_kill && (((r_state == IDLE) && md_start) || (r_state == MUL) || (r_state == DIV));

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Self-checking bench for exe_muldiv_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_exe_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        md_start;
  logic [2:0]  md_funct3;
  logic [31:0] md_rs1;
  logic [31:0] md_rs2;
  logic        md_hold;
  logic        md_kill;
  logic [31:0] md_result;
  logic        md_done;
  logic        md_stall;

  int          n_cmp;
  int          n_bad;
  logic [31:0] last_res;

  exe_muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .md_start  (md_start),
    .md_funct3 (md_funct3),
    .md_rs1    (md_rs1),
    .md_rs2    (md_rs2),
    .md_hold   (md_hold),
    .md_kill   (md_kill),
    .md_result (md_result),
    .md_done   (md_done),
    .md_stall  (md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model straight from the RV32M definitions using 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int          sa_i, sb_i;
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa_i = a; sb_i = b;
    sa = sa_i; sb = sb_i;
    ua = {32'd0, a}; ub = {32'd0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called at negedge+1 with the unit in IDLE; returns at negedge+1 in IDLE.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int hold_n, input bit drop_start);
    logic [31:0] exp;
    int          exp_lat, cyc, stalls;
    exp     = model(f3, a, b);
    exp_lat = latency(f3, a, b);
    md_funct3 = f3; md_rs1 = a; md_rs2 = b;
    md_start  = 1'b1;
    md_hold   = (hold_n > 0);
    #1;
    cyc = 0; stalls = 0;
    while (!md_done && cyc < 40) begin
      if (md_stall) stalls++;
      cyc++;
      @(negedge clk); #1;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_stall_cycles"}, stalls, exp_lat);
    check({tag, "_result"}, md_result, exp);
    // Operand changes after issue must not disturb the held result.
    md_rs1 = ~a; md_rs2 = $urandom; md_funct3 = 3'($urandom_range(0, 7));
    for (int i = 0; i < hold_n; i++) begin
      @(negedge clk); #1;
      check({tag, "_hold_done"}, md_done, 1'b1);
      check({tag, "_hold_result"}, md_result, exp);
      check({tag, "_hold_stall"}, md_stall, 1'b0);
    end
    md_hold = 1'b0;
    if (drop_start) md_start = 1'b0;
    @(negedge clk); #1;
    check({tag, "_back_to_idle"}, md_done, 1'b0);
    last_res = exp;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; last_res = 32'd0;
    reset = 1'b0; md_start = 1'b0; md_funct3 = 3'd0;
    md_rs1 = 32'd0; md_rs2 = 32'd0; md_hold = 1'b0; md_kill = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_result", md_result, 32'd0);
    check("reset_done", md_done, 1'b0);
    check("reset_stall", md_stall, 1'b0);
    @(negedge clk); reset = 1'b1; #1;

    // Directed cases from the RV32M corner list.
    run_op("mul_7x-3",   3'd0, 32'd7, 32'hFFFF_FFFD, 0, 1);
    run_op("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 0, 1);
    run_op("mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    run_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    run_op("div_-7_2",   3'd4, 32'hFFFF_FFF9, 32'd2, 0, 1);
    run_op("rem_-7_2",   3'd6, 32'hFFFF_FFF9, 32'd2, 0, 1);
    run_op("divu_7_2",   3'd5, 32'd7, 32'd2, 0, 1);
    run_op("remu_7_2",   3'd7, 32'd7, 32'd2, 0, 1);
    run_op("div_by_0",   3'd4, 32'd5, 32'd0, 0, 1);
    run_op("remu_by_0",  3'd7, 32'd5, 32'd0, 0, 1);
    run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
    run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
    run_op("hold4",      3'd0, 32'd1234, 32'd5678, 4, 1);

    // Kill in the tenth DIV cycle, then a clean divide.
    md_funct3 = 3'd5; md_rs1 = 32'd1000; md_rs2 = 32'd3; md_start = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("kill_pre_stall", md_stall, 1'b1);
    md_kill = 1'b1; md_start = 1'b0; #1;
    check("kill_stall", md_stall, 1'b0);
    @(negedge clk); md_kill = 1'b0; #1;
    check("kill_done", md_done, 1'b0);
    check("kill_idle_stall", md_stall, 1'b0);
    check("kill_result_kept", md_result, last_res);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 0, 1);

    // Reset asserted in the MUL cycle.
    md_funct3 = 3'd0; md_rs1 = 32'd9; md_rs2 = 32'd9; md_start = 1'b1;
    @(negedge clk); #1;
    check("rst_mid_stall_pre", md_stall, 1'b1);
    reset = 1'b0; md_start = 1'b0; #1;
    check("rst_mid_result", md_result, 32'd0);
    check("rst_mid_done", md_done, 1'b0);
    check("rst_mid_stall", md_stall, 1'b0);
    @(negedge clk); reset = 1'b1; #1;

    // Back-to-back: start stays high across DONE into the next op.
    run_op("b2b_mul", 3'd0, 32'd11, 32'd13, 0, 0);
    run_op("b2b_div", 3'd4, 32'hFFFF_FF9C, 32'd7, 0, 0);
    run_op("b2b_mulhu", 3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1, 1);

    // Random operations, some back-to-back, some with hold.
    for (int i = 0; i < 60; i++) begin
      run_op("rand", 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end
    md_start = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
